// File: rtl/fanout_branch_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fanout_branch_sequencer: staggered on/off sequencing of buffer branches   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module fanout_branch_sequencer #(
  parameter int NUM_BRANCHES = 4,
  parameter int STAGGER      = 3,
  parameter int GW           = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_req,
  input  logic [NUM_BRANCHES-1:0] branch_mask,
  output logic [NUM_BRANCHES-1:0] branch_en,
  output logic                    busy,
  output logic                    all_on,
  output logic                    all_off,
  output logic                    done
);

  typedef enum logic [1:0] {
    S_OFF       = 2'd0,
    S_RAMP_UP   = 2'd1,
    S_ON        = 2'd2,
    S_RAMP_DOWN = 2'd3
  } state_t;

  localparam logic [GW-1:0] c_g_max = GW'(STAGGER - 1);
  localparam logic [GW-1:0] c_g_one = GW'(1);

  state_t                  state_q, state_d;
  logic [NUM_BRANCHES-1:0] en_q, en_d;
  logic [NUM_BRANCHES-1:0] mask_q, mask_d;
  logic [GW-1:0]           g_q, g_d;
  logic                    done_q, done_d;
  logic                    busy_q, all_on_q, all_off_q;
  logic                    w_allowed;
  logic [NUM_BRANCHES-1:0] w_up_bit, w_dn_bit, w_first_bit;

  function automatic logic [NUM_BRANCHES-1:0] lowest_bit(input logic [NUM_BRANCHES-1:0] v);
    lowest_bit = '0;
    for (int i = NUM_BRANCHES - 1; i >= 0; i--) begin
      if (v[i]) lowest_bit = NUM_BRANCHES'(1) << i;
    end
  endfunction

  function automatic logic [NUM_BRANCHES-1:0] highest_bit(input logic [NUM_BRANCHES-1:0] v);
    highest_bit = '0;
    for (int i = 0; i < NUM_BRANCHES; i++) begin
      if (v[i]) highest_bit = NUM_BRANCHES'(1) << i;
    end
  endfunction

  assign w_allowed   = (g_q == c_g_max);
  assign w_up_bit    = lowest_bit(mask_q & ~en_q);
  assign w_dn_bit    = highest_bit(en_q);
  assign w_first_bit = lowest_bit(branch_mask);

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    mask_d  = mask_q;
    done_d  = 1'b0;

    case (state_q)
      S_OFF: begin
        if (en_req && (branch_mask != '0) && w_allowed) begin
          mask_d  = branch_mask;
          en_d    = w_first_bit;
          state_d = (w_first_bit == branch_mask) ? S_ON : S_RAMP_UP;
          done_d  = (w_first_bit == branch_mask);
        end
      end
      S_RAMP_UP, S_RAMP_DOWN: begin
        if (en_req) begin
          state_d = S_RAMP_UP;
          if (w_allowed) begin
            en_d = en_q | w_up_bit;
            if ((en_q | w_up_bit) == mask_q) begin
              state_d = S_ON;
              done_d  = 1'b1;
            end
          end
        end else begin
          state_d = S_RAMP_DOWN;
          if (w_allowed) begin
            en_d = en_q & ~w_dn_bit;
            if ((en_q & ~w_dn_bit) == '0) begin
              state_d = S_OFF;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: begin
        if (!en_req && w_allowed) begin
          en_d    = en_q & ~w_dn_bit;
          state_d = ((en_q & ~w_dn_bit) == '0) ? S_OFF : S_RAMP_DOWN;
          done_d  = ((en_q & ~w_dn_bit) == '0);
        end
      end
    endcase

    // The latched mask only lives for one power-up/power-down cycle.
    if (state_d == S_OFF) mask_d = '0;

    if (en_d != en_q)     g_d = '0;
    else if (w_allowed)   g_d = g_q;
    else                  g_d = g_q + c_g_one;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_OFF;
      en_q      <= '0;
      mask_q    <= '0;
      g_q       <= c_g_max;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      all_on_q  <= 1'b0;
      all_off_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      mask_q    <= mask_d;
      g_q       <= g_d;
      done_q    <= done_d;
      busy_q    <= (state_d == S_RAMP_UP) || (state_d == S_RAMP_DOWN);
      all_on_q  <= (state_d == S_ON);
      all_off_q <= (state_d == S_OFF);
    end
  end

  assign branch_en = en_q;
  assign busy      = busy_q;
  assign all_on    = all_on_q;
  assign all_off   = all_off_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: doc/fanout_branch_sequencer.md
Name: fanout_branch_sequencer

Overview:
- Sequences the enables of the parallel buffer branches in a high-fanout buffer tree, where one driver feeds N buffered branches.
- Branches are turned on lowest-index first and off highest-index first, one at a time, with a guaranteed minimum gap between changes. This limits simultaneous-switching current when a wide fanout net is brought up or down.
- Sits between the power/mode controller (en_req) and the branch buffer enable pins.

Parameters:
- NUM_BRANCHES, 4, number of buffered branches controlled (1..16).
- STAGGER, 3, minimum clock cycles between any two changes of branch_en (>=1).
- GW, 4, width of the gap counter; must hold STAGGER-1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en_req  input  1  level request: 1 = all masked branches on, 0 = all branches off.
- branch_mask  input  NUM_BRANCHES  branches participating in the next power-up; sampled only in OFF.
- branch_en  output  NUM_BRANCHES  enable per buffer branch.
- busy  output  1  high in RAMP_UP or RAMP_DOWN.
- all_on  output  1  high in ON.
- all_off  output  1  high in OFF.
- done  output  1  one-cycle pulse on arrival in ON or OFF after a ramp.

Behaviour:
- Reset (async, any state, mid-ramp included):
  - branch_en=0, busy=0, all_on=0, done=0, all_off=1.
  - State=OFF, latched mask=0.
  - Gap counter g=STAGGER-1 (saturated), so the first action after reset is immediate.
- Gap counter g:
  - Cleared to 0 on any edge that changes branch_en.
  - Otherwise increments, saturating at STAGGER-1.
  - An action is allowed on an edge only when g==STAGGER-1 before that edge.
  - Invariant: consecutive branch_en changes are at least STAGGER edges apart. At most one bit of branch_en changes per edge.
- States: OFF, RAMP_UP, ON, RAMP_DOWN.
- OFF:
  - If en_req=1, branch_mask!=0 and the action is allowed: latch branch_mask, set its lowest set bit in branch_en.
  - Then go to RAMP_UP, or straight to ON if the mask has exactly one bit.
  - If en_req=1 with branch_mask=0: stay in OFF, no done pulse.
- RAMP_UP:
  - en_req=1: on each allowed edge, set the lowest latched-mask bit not yet enabled. The edge that completes the mask goes to ON.
  - en_req=0: go to RAMP_DOWN on the same edge. If that edge is allowed, clear the highest enabled bit on it; otherwise wait for the next allowed edge.
- ON:
  - en_req=0 and allowed: clear the highest enabled bit, go to RAMP_DOWN (or OFF if only one bit was set).
  - en_req=0 and not allowed: wait in ON until allowed.
- RAMP_DOWN:
  - en_req=0: on each allowed edge, clear the highest enabled bit. Reaching branch_en=0 goes to OFF.
  - en_req=1: go to RAMP_UP with the same allowed-edge rule, re-enabling the lowest disabled latched bit.
- Latched mask:
  - Held from the first enable until OFF is reached.
  - branch_mask changes outside OFF are ignored.
  - Unmasked branches never assert.
- done:
  - Registered; high for exactly the first cycle in ON or OFF reached via a ramp or single-step transition.
  - Not asserted after reset, and not for the mask=0 case.
- busy, all_on and all_off are registered decodes of state and change on the same edge as the state.
- Latency: branch_en updates on the edge that samples the qualifying en_req; there is no combinational input-to-output path.

Test Plan:
- NUM_BRANCHES=4, STAGGER=3, mask=4'b1111, en_req rises before edge 0 -> branch_en=0001 after edge 0, 0011 after edge 3, 0111 after edge 6, 1111 after edge 9; all_on and done high after edge 9, done low after edge 10.
- From ON, en_req falls before edge 20 -> branch_en=0111 after edge 20, 0011 after 23, 0001 after 26, 0000 after 29; all_off and done pulse after 29.
- mask=4'b1010 -> 0010 after edge 0, 1010 after edge 3, then ON; changing mask to 1111 during ON has no effect.
- Abort: en_req drops one cycle after 0011 is set -> state RAMP_DOWN, 0001 exactly 3 edges after the last change, 0000 3 edges later. The bench asserts no two changes fewer than 3 edges apart throughout.
- rst pulsed mid-RAMP_UP (branch_en=0011) -> outputs 0 and all_off=1 immediately without a clock. After release with en_req=1, 0001 appears on the first edge.
- mask=0 with en_req=1 for 10 cycles -> branch_en stays 0, no done. STAGGER=1 full ramp -> enables set on 4 consecutive edges.
